branch_target_buffer: RTL and testbench
=======================================

// Module: branch_target_buffer
//
// PURPOSE
// Direct-mapped branch target buffer (BTB): the table side of the 2-bit branch predictor.
// Fetch side: combinational lookup by PC returns hit, predicted direction and target.
// Resolve side: one update per cycle carrying the actual branch outcome.
// Each update reads the stored 2-bit counter, applies the saturating transition and writes the new counter back.
// Sits between the fetch stage (lookup) and the execute/branch-resolve stage (update).
//
// PARAMETERS
// ENTRIES     16   number of table entries; power of two, >= 2
// INDEX_BITS  4    log2(ENTRIES); index = pc[INDEX_BITS+1:2]
// XLEN        32   PC/target width; tag = pc[XLEN-1:INDEX_BITS+2]
//
// PORTS
// btb_clk            in   1     clock, all state on rising edge
// btb_rst            in   1     synchronous reset, active-high
// btb_lookup_pc      in   XLEN  fetch PC
// btb_lookup_hit     out  1     entry valid and tag match
// btb_lookup_taken   out  1     counter[1] of hit entry; 0 on miss
// btb_lookup_target  out  XLEN  stored target of hit entry; 0 on miss
// btb_update_valid   in   1     resolved branch present this cycle (always accepted)
// btb_update_pc      in   XLEN  PC of resolved branch
// btb_update_taken   in   1     actual outcome
// btb_update_target  in   XLEN  actual target (meaningful when taken)
//
// BEHAVIOUR
// - Entry contents: valid, tag, target, 2-bit counter.
//   Counter encodings: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
// - Counter transitions:
//   - Taken: 00->01, 01->10, 10->11, 11->11.
//   - Not taken: 11->10, 10->01, 01->00, 00->00.
// - Reset: all valid bits cleared and the U1 stage cleared, so any pending write is discarded.
//   While btb_rst=1, all lookup outputs are forced to 0.
//   Reset asserted mid-update drops that update entirely.
// - Lookup: purely combinational, zero latency.
//   On a miss, hit, taken and target are all 0.
// - Update pipeline, for an update presented in cycle N:
//   - Edge N->N+1: inputs captured into the U1 register (valid, index, tag, taken, target).
//   - Cycle N+1: U1 reads its entry and computes the write data.
//     - Hit (valid and tag match): counter <- transition(counter, taken).
//       If taken, target <- U1 target; otherwise the target is kept.
//     - Miss and taken: allocate. valid=1, tag, target, counter=10. Any aliasing entry is overwritten.
//     - Miss and not taken: no write.
//   - Edge N+1->N+2: array written.
// - Bypass: in cycle N+1, a lookup whose index equals the U1 index with a pending write returns the U1 write data.
//   This makes update->lookup visibility exactly one cycle.
// - Back-to-back updates: an update every cycle, including to the same index, needs no stall.
//   The U1 read in cycle N+2 already sees the write from edge N+1->N+2.
// - Lookup and update in the same cycle to the same index: the lookup sees the pre-update contents.
// - Update PCs are aligned; pc[1:0] is ignored.
//
// STRUCTURE
// - btb_pkg:
//   - btb_ctr_t: 2-bit enum with the encodings above.
//   - BTB_CTR_ALLOC = 2'b10.
//   - function btb_ctr_next(btb_ctr_t, logic taken).
//   - btb_entry_t: packed struct {valid, tag, target, ctr}.
// - Sub-module btb_storage: ENTRIES x btb_entry_t array.
//   - One async read port for lookup, one for U1.
//   - One sync write port.
//   - Synchronous valid clear on btb_rst.
// - Top level holds the U1 register, hit/allocate logic and the bypass mux.
//
// TESTING (default params: index=pc[5:2])
// 1. Reset 2 cycles, then lookup 0x100 -> hit=0, taken=0, target=0x0.
// 2. Update pc=0x104, taken=1, target=0x200 in cycle N.
//    Lookup 0x104 in N+1 (bypass) and N+2 -> hit=1, taken=1 (ctr 10), target=0x200.
// 3. Follow with three not-taken updates to 0x104 -> ctr 01, 00, 00.
//    Lookup taken=0 from the first, hit=1 and target=0x200 throughout.
//    Then four taken updates -> ctr 01, 10, 11, 11.
// 4. Alias: taken update pc=0x144 (same index 1), target=0x300.
//    Lookup 0x104 -> hit=0; lookup 0x144 -> hit=1, target=0x300, ctr 10.
// 5. Not-taken update to empty 0x108 -> no allocation; lookup 0x108 hit=0 in N+1 and N+2.
// 6. Taken update 0x10C in cycle N, btb_rst=1 in cycle N+1.
//    Lookup 0x10C after reset -> hit=0. During reset all lookup outputs are 0.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types for the branch target buffer: counter encoding, entry layout, counter update.
// Latency: none (types and a pure function).
// Backpressure: none.
package btb_pkg;

    localparam int BTB_ENTRIES    = 16;
    localparam int BTB_INDEX_BITS = 4;
    localparam int BTB_XLEN       = 32;
    localparam int BTB_TAG_BITS   = BTB_XLEN - BTB_INDEX_BITS - 2;

    typedef enum logic [1:0] {
        BTB_CTR_SNT = 2'b00,
        BTB_CTR_WNT = 2'b01,
        BTB_CTR_WT  = 2'b10,
        BTB_CTR_ST  = 2'b11
    } btb_ctr_t;

    // A freshly allocated branch starts as weakly taken.
    localparam btb_ctr_t BTB_CTR_ALLOC = BTB_CTR_WT;

    typedef struct packed {
        logic                    valid;
        logic [BTB_TAG_BITS-1:0] tag;
        logic [BTB_XLEN-1:0]     target;
        btb_ctr_t                ctr;
    } btb_entry_t;

    // Saturating 2-bit counter step towards the observed outcome.
    function automatic btb_ctr_t btb_ctr_next(input btb_ctr_t ctr, input logic taken);
        btb_ctr_t nxt;
        nxt = ctr;
        case (ctr)
            BTB_CTR_SNT: nxt = taken ? BTB_CTR_WNT : BTB_CTR_SNT;
            BTB_CTR_WNT: nxt = taken ? BTB_CTR_WT  : BTB_CTR_SNT;
            BTB_CTR_WT:  nxt = taken ? BTB_CTR_ST  : BTB_CTR_WNT;
            BTB_CTR_ST:  nxt = taken ? BTB_CTR_ST  : BTB_CTR_WT;
            default:     nxt = BTB_CTR_SNT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/btb_storage.sv
// Direct-mapped BTB entry array: two asynchronous read ports, one synchronous write port.
// Latency: reads combinational, writes visible after the next rising edge.
// Backpressure: none; a write is taken every cycle it is requested, reset drops it.
module btb_storage
    import btb_pkg::*;
#(
    parameter int ENTRIES    = BTB_ENTRIES,
    parameter int INDEX_BITS = BTB_INDEX_BITS
) (
    input  logic                  btb_clk,
    input  logic                  btb_rst,
    input  logic [INDEX_BITS-1:0] rd_a_idx,
    output btb_entry_t            rd_a_entry,
    input  logic [INDEX_BITS-1:0] rd_b_idx,
    output btb_entry_t            rd_b_entry,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  btb_entry_t            wr_entry
);

    // Valid bits live apart from the payload so reset only has to clear one vector.
    logic [ENTRIES-1:0]      valid_q;
    logic [BTB_TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [BTB_XLEN-1:0]     target_q [ENTRIES];
    btb_ctr_t                ctr_q    [ENTRIES];

    // Reset invalidates every entry and wins over a write landing on the same edge.
    always_ff @(posedge btb_clk) begin
        if (btb_rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx]  <= wr_entry.valid;
            tag_q[wr_idx]    <= wr_entry.tag;
            target_q[wr_idx] <= wr_entry.target;
            ctr_q[wr_idx]    <= wr_entry.ctr;
        end
    end

    // Both read ports are plain array reads reassembled into the entry struct.
    always_comb begin
        rd_a_entry        = '0;
        rd_a_entry.valid  = valid_q[rd_a_idx];
        rd_a_entry.tag    = tag_q[rd_a_idx];
        rd_a_entry.target = target_q[rd_a_idx];
        rd_a_entry.ctr    = ctr_q[rd_a_idx];
        rd_b_entry        = '0;
        rd_b_entry.valid  = valid_q[rd_b_idx];
        rd_b_entry.tag    = tag_q[rd_b_idx];
        rd_b_entry.target = target_q[rd_b_idx];
        rd_b_entry.ctr    = ctr_q[rd_b_idx];
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with combinational fetch lookup and a two-stage read-modify-write update path.
// Latency: lookup 0 cycles; an update becomes visible to lookup one cycle after it is presented.
// Backpressure: none; one update accepted every cycle, back-to-back to the same index without stall.
module branch_target_buffer
    import btb_pkg::*;
#(
    parameter int ENTRIES    = BTB_ENTRIES,
    parameter int INDEX_BITS = BTB_INDEX_BITS,
    parameter int XLEN       = BTB_XLEN
) (
    input  logic            btb_clk,
    input  logic            btb_rst,
    input  logic [XLEN-1:0] btb_lookup_pc,
    output logic            btb_lookup_hit,
    output logic            btb_lookup_taken,
    output logic [XLEN-1:0] btb_lookup_target,
    input  logic            btb_update_valid,
    input  logic [XLEN-1:0] btb_update_pc,
    input  logic            btb_update_taken,
    input  logic [XLEN-1:0] btb_update_target
);

    // Instruction PCs are word aligned, so the low two bits carry no information.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{btb_lookup_pc[1:0], btb_update_pc[1:0]};

    // U1 stage: captured update waiting for its read-modify-write.
    logic                    u1_vld;
    logic [INDEX_BITS-1:0]   u1_idx;
    logic [BTB_TAG_BITS-1:0] u1_tag;
    logic                    u1_taken;
    logic [XLEN-1:0]         u1_target;

    logic [INDEX_BITS-1:0]   lk_idx;
    logic [BTB_TAG_BITS-1:0] lk_tag;
    btb_entry_t              lk_rd_entry;
    btb_entry_t              lk_entry;
    btb_entry_t              u1_entry;
    logic                    u1_hit;
    logic                    wr_en;
    btb_entry_t              wr_entry;
    logic                    lk_hit;

    assign lk_idx = btb_lookup_pc[INDEX_BITS+1:2];
    assign lk_tag = btb_lookup_pc[XLEN-1:INDEX_BITS+2];

    // Capture the resolved branch; reset discards anything in flight.
    always_ff @(posedge btb_clk) begin
        if (btb_rst) begin
            u1_vld <= 1'b0;
        end else begin
            u1_vld <= btb_update_valid;
        end
        u1_idx    <= btb_update_pc[INDEX_BITS+1:2];
        u1_tag    <= btb_update_pc[XLEN-1:INDEX_BITS+2];
        u1_taken  <= btb_update_taken;
        u1_target <= btb_update_target;
    end

    btb_storage #(
        .ENTRIES    (ENTRIES),
        .INDEX_BITS (INDEX_BITS)
    ) u_storage (
        .btb_clk    (btb_clk),
        .btb_rst    (btb_rst),
        .rd_a_idx   (lk_idx),
        .rd_a_entry (lk_rd_entry),
        .rd_b_idx   (u1_idx),
        .rd_b_entry (u1_entry),
        .wr_en      (wr_en),
        .wr_idx     (u1_idx),
        .wr_entry   (wr_entry)
    );

    assign u1_hit = u1_entry.valid && (u1_entry.tag == u1_tag);

    // Hit: train the counter (retarget only when taken); taken miss: allocate over whatever aliases there.
    always_comb begin
        wr_en    = 1'b0;
        wr_entry = '0;
        if (u1_vld) begin
            if (u1_hit) begin
                wr_en           = 1'b1;
                wr_entry.valid  = 1'b1;
                wr_entry.tag    = u1_tag;
                wr_entry.target = u1_taken ? u1_target : u1_entry.target;
                wr_entry.ctr    = btb_ctr_next(u1_entry.ctr, u1_taken);
            end else if (u1_taken) begin
                wr_en           = 1'b1;
                wr_entry.valid  = 1'b1;
                wr_entry.tag    = u1_tag;
                wr_entry.target = u1_target;
                wr_entry.ctr    = BTB_CTR_ALLOC;
            end
        end
    end

    // Forward the pending write so the fetch side sees an update one cycle after it resolves.
    always_comb begin
        lk_entry = lk_rd_entry;
        if (wr_en && (u1_idx == lk_idx)) begin
            lk_entry = wr_entry;
        end
    end

    assign lk_hit            = !btb_rst && lk_entry.valid && (lk_entry.tag == lk_tag);
    assign btb_lookup_hit    = lk_hit;
    assign btb_lookup_taken  = lk_hit && lk_entry.ctr[1];
    assign btb_lookup_target = lk_hit ? lk_entry.target : '0;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed, table-driven bench for branch_target_buffer with hand-computed expectations.
// Latency: one vector per clock cycle, lookup outputs sampled on the falling edge.
// Backpressure: none; the DUT accepts every update.
module tb_branch_target_buffer;

    logic        btb_clk;
    logic        btb_rst;
    logic [31:0] btb_lookup_pc;
    logic        btb_lookup_hit;
    logic        btb_lookup_taken;
    logic [31:0] btb_lookup_target;
    logic        btb_update_valid;
    logic [31:0] btb_update_pc;
    logic        btb_update_taken;
    logic [31:0] btb_update_target;

    int checks;
    int failures;

    typedef struct {
        string       name;
        logic        rst;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic [31:0] lpc;
        logic        eh;
        logic        et;
        logic [31:0] etgt;
    } vec_t;

    vec_t vecs[$];

    branch_target_buffer dut (
        .btb_clk           (btb_clk),
        .btb_rst           (btb_rst),
        .btb_lookup_pc     (btb_lookup_pc),
        .btb_lookup_hit    (btb_lookup_hit),
        .btb_lookup_taken  (btb_lookup_taken),
        .btb_lookup_target (btb_lookup_target),
        .btb_update_valid  (btb_update_valid),
        .btb_update_pc     (btb_update_pc),
        .btb_update_taken  (btb_update_taken),
        .btb_update_target (btb_update_target)
    );

    initial btb_clk = 1'b0;
    always #5 btb_clk = ~btb_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic v(input string nm, input logic rst, input logic uv, input logic [31:0] upc,
                     input logic ut, input logic [31:0] utgt, input logic [31:0] lpc,
                     input logic eh, input logic et, input logic [31:0] etgt);
        vec_t x;
        x.name = nm; x.rst = rst; x.uv = uv; x.upc = upc; x.ut = ut; x.utgt = utgt;
        x.lpc = lpc; x.eh = eh; x.et = et; x.etgt = etgt;
        vecs.push_back(x);
    endtask

    // One cycle: drive just after the rising edge, check on the falling edge.
    task automatic cyc(input vec_t x);
        @(posedge btb_clk);
        #1;
        btb_rst           = x.rst;
        btb_update_valid  = x.uv;
        btb_update_pc     = x.upc;
        btb_update_taken  = x.ut;
        btb_update_target = x.utgt;
        btb_lookup_pc     = x.lpc;
        @(negedge btb_clk);
        chk({x.name, ".hit"},    {31'd0, btb_lookup_hit},   {31'd0, x.eh});
        chk({x.name, ".taken"},  {31'd0, btb_lookup_taken}, {31'd0, x.et});
        chk({x.name, ".target"}, btb_lookup_target,         x.etgt);
    endtask

    task automatic hand(input string nm, input logic rst, input logic uv, input logic [31:0] upc,
                        input logic ut, input logic [31:0] utgt, input logic [31:0] lpc,
                        input logic eh, input logic et, input logic [31:0] etgt);
        vec_t x;
        x.name = nm; x.rst = rst; x.uv = uv; x.upc = upc; x.ut = ut; x.utgt = utgt;
        x.lpc = lpc; x.eh = eh; x.et = et; x.etgt = etgt;
        cyc(x);
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        btb_rst           = 1'b1;
        btb_update_valid  = 1'b0;
        btb_update_pc     = '0;
        btb_update_taken  = 1'b0;
        btb_update_target = '0;
        btb_lookup_pc     = 32'h100;

        //   name    rst uv upc       ut utgt      lpc       eh et etgt
        v("rst0",   1, 0, 32'h0,   0, 32'h0,   32'h100, 0, 0, 32'h0);
        v("rst1",   1, 0, 32'h0,   0, 32'h0,   32'h100, 0, 0, 32'h0);
        v("t1",     0, 0, 32'h0,   0, 32'h0,   32'h100, 0, 0, 32'h0);
        // allocate 0x104: miss in the same cycle, bypass next, array after
        v("t2a",    0, 1, 32'h104, 1, 32'h200, 32'h104, 0, 0, 32'h0);
        v("t2b",    0, 0, 32'h0,   0, 32'h0,   32'h104, 1, 1, 32'h200);
        v("t2c",    0, 0, 32'h0,   0, 32'h0,   32'h104, 1, 1, 32'h200);
        // three not-taken: 10 -> 01 -> 00 -> 00
        v("t3a",    0, 1, 32'h104, 0, 32'h0,   32'h104, 1, 1, 32'h200);
        v("t3b",    0, 1, 32'h104, 0, 32'h0,   32'h104, 1, 0, 32'h200);
        v("t3c",    0, 1, 32'h104, 0, 32'h0,   32'h104, 1, 0, 32'h200);
        v("t3d",    0, 0, 32'h0,   0, 32'h0,   32'h104, 1, 0, 32'h200);
        // four taken: 00 -> 01 -> 10 -> 11 -> 11, last one retargets
        v("t3e",    0, 1, 32'h104, 1, 32'h200, 32'h104, 1, 0, 32'h200);
        v("t3f",    0, 1, 32'h104, 1, 32'h200, 32'h104, 1, 0, 32'h200);
        v("t3g",    0, 1, 32'h104, 1, 32'h200, 32'h104, 1, 1, 32'h200);
        v("t3h",    0, 1, 32'h104, 1, 32'h220, 32'h104, 1, 1, 32'h200);
        v("t3i",    0, 0, 32'h0,   0, 32'h0,   32'h104, 1, 1, 32'h220);
        // two not-taken from 11: 10 (still taken), then 01; target kept
        v("t3j",    0, 1, 32'h104, 0, 32'h888, 32'h104, 1, 1, 32'h220);
        v("t3k",    0, 1, 32'h104, 0, 32'h888, 32'h104, 1, 1, 32'h220);
        v("t3l",    0, 0, 32'h0,   0, 32'h0,   32'h104, 1, 0, 32'h220);
        // alias 0x144 onto index 1, then one not-taken to expose ctr 10
        v("t4a",    0, 1, 32'h144, 1, 32'h300, 32'h104, 1, 0, 32'h220);
        v("t4b",    0, 0, 32'h0,   0, 32'h0,   32'h104, 0, 0, 32'h0);
        v("t4c",    0, 1, 32'h144, 0, 32'h0,   32'h144, 1, 1, 32'h300);
        v("t4d",    0, 0, 32'h0,   0, 32'h0,   32'h144, 1, 0, 32'h300);
        // not-taken miss never allocates
        v("t5a",    0, 1, 32'h108, 0, 32'h400, 32'h108, 0, 0, 32'h0);
        v("t5b",    0, 0, 32'h0,   0, 32'h0,   32'h108, 0, 0, 32'h0);
        v("t5c",    0, 0, 32'h0,   0, 32'h0,   32'h108, 0, 0, 32'h0);
        // reset while the 0x10C allocation sits in U1
        v("t6a",    0, 1, 32'h10C, 1, 32'h500, 32'h10C, 0, 0, 32'h0);
        v("t6b",    1, 0, 32'h0,   0, 32'h0,   32'h10C, 0, 0, 32'h0);
        v("t6c",    0, 0, 32'h0,   0, 32'h0,   32'h10C, 0, 0, 32'h0);
        v("t6d",    0, 0, 32'h0,   0, 32'h0,   32'h144, 0, 0, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i]);
        end

        // Unaligned PC bits are ignored on both ports.
        hand("h1a", 0, 1, 32'h183, 1, 32'h600, 32'h180, 0, 0, 32'h0);
        hand("h1b", 0, 0, 32'h0,   0, 32'h0,   32'h181, 1, 1, 32'h600);
        hand("h1c", 0, 0, 32'h0,   0, 32'h0,   32'h182, 1, 1, 32'h600);
        // Same-cycle update and lookup: lookup sees pre-update contents.
        hand("h2a", 0, 1, 32'h180, 0, 32'h0,   32'h180, 1, 1, 32'h600);
        hand("h2b", 0, 0, 32'h0,   0, 32'h0,   32'h180, 1, 0, 32'h600);
        // Reset forces outputs low on a valid array entry and clears it.
        hand("h3a", 1, 0, 32'h0,   0, 32'h0,   32'h180, 0, 0, 32'h0);
        hand("h3b", 0, 0, 32'h0,   0, 32'h0,   32'h180, 0, 0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
